// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC receive deframer; flag/abort detection, zero removal and byte assembly.
// Bits reach the content path only after leaving the 8-bit window unmatched by a flag or abort.
module hdlc_rx_deframer #(
    parameter int MAX_FRAME_BYTES = 128
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       Rx_Enable,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_AbortSignal,
    output logic       Rx_ValidFrame,
    output logic [7:0] Rx_Data,
    output logic       Rx_WrBuff,
    output logic       Rx_EoF,
    output logic       Rx_FrameError,
    output logic       Rx_Overflow,
    output logic [7:0] Rx_FrameSize
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FRAME = 1'b1;
    localparam logic [7:0] MAX_BYTES = 8'(MAX_FRAME_BYTES);

    logic [0:0] state;
    logic [7:0] window, marked, byteCnt;
    logic [2:0] bitCnt, onesCnt;
    logic       cBit, cValid, flagNow, abortNow, hit, stuffed;

    always_comb begin
        flagNow  = window == 8'h7E;
        abortNow = window == 8'hFE;
        hit      = flagNow | abortNow;
        stuffed  = !cBit && onesCnt == 3'd5;
    end

    assign Rx_ValidFrame = state == FRAME;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state          <= IDLE;
            window         <= 8'hFF;
            marked         <= 8'h00;
            byteCnt        <= 8'd0;
            bitCnt         <= 3'd0;
            onesCnt        <= 3'd0;
            cBit           <= 1'b1;
            cValid         <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            Rx_Data        <= 8'h00;
            Rx_WrBuff      <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_FrameError  <= 1'b0;
            Rx_Overflow    <= 1'b0;
            Rx_FrameSize   <= 8'd0;
        end else begin
            window         <= {Rx, window[7:1]};
            // every bit inside a matched window is marked so it never becomes content
            marked         <= {1'b0, marked[7:1] | {7{hit}}};
            cBit           <= window[0];
            cValid         <= !(marked[0] | hit);
            Rx_FlagDetect  <= flagNow;
            Rx_AbortDetect <= abortNow;
            Rx_WrBuff      <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_FrameError  <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            if (state == IDLE) begin
                if (flagNow && Rx_Enable) begin
                    state   <= FRAME;
                    byteCnt <= 8'd0;
                    bitCnt  <= 3'd0;
                    onesCnt <= 3'd0;
                end
            end else if (!Rx_Enable) begin
                state       <= IDLE;
                Rx_Overflow <= 1'b0;
            end else if (Rx_AbortDetect) begin
                state          <= IDLE;
                Rx_AbortSignal <= 1'b1;
                Rx_Overflow    <= 1'b0;
            end else if (Rx_FlagDetect) begin
                if (byteCnt == 8'd0) begin
                    bitCnt  <= 3'd0;
                    onesCnt <= 3'd0;
                end else begin
                    state         <= IDLE;
                    Rx_EoF        <= 1'b1;
                    Rx_FrameError <= bitCnt != 3'd0;
                    Rx_FrameSize  <= byteCnt;
                    Rx_Overflow   <= 1'b0;
                end
            end else if (cValid) begin
                if (stuffed) begin
                    onesCnt <= 3'd0;
                end else begin
                    onesCnt <= cBit ? onesCnt + 3'd1 : 3'd0;
                    Rx_Data <= {cBit, Rx_Data[7:1]};
                    bitCnt  <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        if (byteCnt == MAX_BYTES) begin
                            Rx_Overflow <= 1'b1;
                        end else begin
                            Rx_WrBuff <= 1'b1;
                            byteCnt   <= byteCnt + 8'd1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: drives bit-stuffed HDLC frames and scoreboards every strobe with its cycle.
module tb_hdlc_rx_deframer;
    localparam int MAXB = 4;

    logic       Clk, Rst, Rx, Rx_Enable;
    logic       Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame;
    logic [7:0] Rx_Data, Rx_FrameSize;
    logic       Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Overflow;
    logic [23:0] allOut;

    hdlc_rx_deframer #(.MAX_FRAME_BYTES(MAXB)) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_Enable(Rx_Enable),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_AbortSignal(Rx_AbortSignal), .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_Data(Rx_Data), .Rx_WrBuff(Rx_WrBuff), .Rx_EoF(Rx_EoF),
        .Rx_FrameError(Rx_FrameError), .Rx_Overflow(Rx_Overflow), .Rx_FrameSize(Rx_FrameSize)
    );

    assign allOut = {Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame, Rx_Data,
                     Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Overflow, Rx_FrameSize};

    typedef struct { logic [63:0] bits; int n; logic [7:0] size; logic err; } vec_t;
    typedef struct { logic [7:0] d; int t; } wr_t;
    typedef struct { logic [7:0] size; logic err; int t; } eof_t;

    vec_t vecs[7];
    int   flagQ[$], abortQ[$], abortSigQ[$], ovfQ[$];
    wr_t  wrQ[$];
    eof_t eofQ[$];

    int checks = 0, failures = 0, edgeCnt = 0, lastT = 0;
    logic [7:0] hist, mByte;
    int mBits, mBytes, ones;
    logic mOvf, enAtEdge, prevValid, prevOvf;
    int eT;
    wr_t w;
    eof_t f;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        edgeCnt  <= edgeCnt + 1;
        enAtEdge <= Rx_Enable;
    end

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @edge %0d", name, act, exp, edgeCnt);
        end
    endtask

    // line model: every sent bit updates an 8-bit history that predicts detect pulses
    task automatic sendBit(input logic b);
        @(negedge Clk);
        Rx = b;
        lastT = edgeCnt + 1;
        hist = {b, hist[7:1]};
        if (hist == 8'h7E) flagQ.push_back(lastT + 1);
        if (hist == 8'hFE) abortQ.push_back(lastT + 1);
    endtask

    task automatic sendFlag();
        sendBit(1'b0);
        repeat (6) sendBit(1'b1);
        sendBit(1'b0);
    endtask

    task automatic beginFrame();
        sendFlag();
        mBits = 0; mBytes = 0; ones = 0; mByte = 8'h00; mOvf = 1'b0;
    endtask

    task automatic contentBit(input logic b);
        wr_t r;
        sendBit(b);
        mByte = {b, mByte[7:1]};
        mBits++;
        if (mBits == 8) begin
            mBits = 0;
            if (mBytes < MAXB) begin
                r.d = mByte; r.t = lastT + 9;
                wrQ.push_back(r);
                mBytes++;
            end else if (!mOvf) begin
                mOvf = 1'b1;
                ovfQ.push_back(lastT + 9);
            end
        end
        ones = b ? ones + 1 : 0;
        if (ones == 5) begin
            sendBit(1'b0);
            ones = 0;
        end
    endtask

    task automatic endFrame(input logic [7:0] size, input logic err);
        eof_t r;
        sendFlag();
        r.size = size; r.err = err; r.t = lastT + 2;
        eofQ.push_back(r);
    endtask

    task automatic sendFrame(input logic [63:0] bits, input int n, input logic [7:0] size, input logic err);
        beginFrame();
        for (int k = 0; k < n; k++) contentBit(bits[k]);
        endFrame(size, err);
    endtask

    always @(negedge Clk) begin
        if (!Rst) begin
            if (Rx_FlagDetect) begin
                if (flagQ.size() == 0) chk("flag_unexpected", 1'b0, edgeCnt, -1);
                else begin eT = flagQ.pop_front(); chk("flag_time", edgeCnt == eT, edgeCnt, eT); end
                if (!prevValid && enAtEdge) chk("open_valid", Rx_ValidFrame, Rx_ValidFrame, 1);
            end
            if (Rx_AbortDetect) begin
                if (abortQ.size() == 0) chk("abort_det_unexpected", 1'b0, edgeCnt, -1);
                else begin eT = abortQ.pop_front(); chk("abort_det_time", edgeCnt == eT, edgeCnt, eT); end
            end
            if (Rx_AbortSignal) begin
                if (abortSigQ.size() == 0) chk("abort_sig_unexpected", 1'b0, edgeCnt, -1);
                else begin eT = abortSigQ.pop_front(); chk("abort_sig_time", edgeCnt == eT, edgeCnt, eT); end
                chk("abort_valid_fall", prevValid && !Rx_ValidFrame, Rx_ValidFrame, 0);
            end
            if (Rx_WrBuff) begin
                if (wrQ.size() == 0) chk("wr_unexpected", 1'b0, Rx_Data, -1);
                else begin
                    w = wrQ.pop_front();
                    chk("wr_data", Rx_Data == w.d, Rx_Data, w.d);
                    chk("wr_time", edgeCnt == w.t, edgeCnt, w.t);
                end
            end
            if (Rx_EoF) begin
                if (eofQ.size() == 0) chk("eof_unexpected", 1'b0, edgeCnt, -1);
                else begin
                    f = eofQ.pop_front();
                    chk("eof_time", edgeCnt == f.t, edgeCnt, f.t);
                    chk("eof_size", Rx_FrameSize == f.size, Rx_FrameSize, f.size);
                    chk("eof_err", Rx_FrameError == f.err, Rx_FrameError, f.err);
                end
                chk("eof_valid_fall", prevValid && !Rx_ValidFrame, Rx_ValidFrame, 0);
                chk("eof_ovf_clear", !Rx_Overflow, Rx_Overflow, 0);
            end
            if (Rx_FrameError && !Rx_EoF) chk("err_without_eof", 1'b0, 1, 0);
            if (Rx_Overflow && !prevOvf) begin
                if (ovfQ.size() == 0) chk("ovf_unexpected", 1'b0, edgeCnt, -1);
                else begin eT = ovfQ.pop_front(); chk("ovf_time", edgeCnt == eT, edgeCnt, eT); end
            end
        end
        prevValid = Rx_ValidFrame;
        prevOvf   = Rx_Overflow;
    end

    initial begin
        Rst = 1'b1; Rx = 1'b1; Rx_Enable = 1'b1; hist = 8'hFF;
        prevValid = 1'b0; prevOvf = 1'b0;
        vecs[0] = '{64'hA5,     8,  8'd1, 1'b0};
        vecs[1] = '{64'hFF,     8,  8'd1, 1'b0};
        vecs[2] = '{64'h3A5,    12, 8'd1, 1'b1};
        vecs[3] = '{64'h7E7E,   16, 8'd2, 1'b0};
        vecs[4] = '{64'hFFFF,   16, 8'd2, 1'b0};
        vecs[5] = '{64'h00,     8,  8'd1, 1'b0};
        vecs[6] = '{64'h123456, 24, 8'd3, 1'b0};
        repeat (3) @(negedge Clk);
        chk("reset_outputs", allOut == 24'd0, allOut, 0);
        Rst = 1'b0;
        repeat (100) sendBit(1'b1);
        chk("idle_outputs", allOut == 24'd0, allOut, 0);
        for (int i = 0; i < 7; i++) begin
            sendFrame(vecs[i].bits, vecs[i].n, vecs[i].size, vecs[i].err);
            repeat (12) sendBit(1'b1);
        end
        // repeated opening flag sharing its zero with the first
        beginFrame();
        repeat (6) sendBit(1'b1);
        sendBit(1'b0);
        for (int k = 0; k < 8; k++) contentBit(vecs[0].bits[k]);
        endFrame(8'd1, 1'b0);
        repeat (12) sendBit(1'b1);
        sendFrame(64'h2112_4433_2211, 48, 8'd4, 1'b0);
        repeat (12) sendBit(1'b1);
        chk("ovf_cleared", Rx_Overflow == 1'b0, Rx_Overflow, 0);
        beginFrame();
        for (int k = 0; k < 8; k++) contentBit(k inside {2, 3, 4, 5});
        sendBit(1'b0);
        repeat (7) sendBit(1'b1);
        abortSigQ.push_back(lastT + 2);
        repeat (12) sendBit(1'b1);
        beginFrame();
        for (int k = 0; k < 8; k++) contentBit(k % 2 == 0);
        repeat (10) sendBit(1'b0);
        chk("frame_open", Rx_ValidFrame == 1'b1, Rx_ValidFrame, 1);
        Rx_Enable = 1'b0;
        sendBit(1'b0);
        chk("enable_drop", Rx_ValidFrame == 1'b0, Rx_ValidFrame, 0);
        repeat (3) sendBit(1'b0);
        repeat (12) sendBit(1'b1);
        sendFlag();
        repeat (12) sendBit(1'b1);
        chk("disabled_no_open", Rx_ValidFrame == 1'b0, Rx_ValidFrame, 0);
        Rx_Enable = 1'b1;
        beginFrame();
        for (int k = 0; k < 4; k++) contentBit(k != 1);
        #2 Rst = 1'b1;
        Rx = 1'b1;
        #1 chk("reset_mid", allOut == 24'd0, allOut, 0);
        hist = 8'hFF;
        wrQ.delete(); flagQ.delete(); abortQ.delete();
        @(negedge Clk);
        Rst = 1'b0;
        sendFrame(vecs[0].bits, vecs[0].n, vecs[0].size, vecs[0].err);
        repeat (20) sendBit(1'b1);
        chk("flag_q_empty", flagQ.size() == 0, flagQ.size(), 0);
        chk("abort_q_empty", abortQ.size() == 0, abortQ.size(), 0);
        chk("abort_sig_q_empty", abortSigQ.size() == 0, abortSigQ.size(), 0);
        chk("wr_q_empty", wrQ.size() == 0, wrQ.size(), 0);
        chk("eof_q_empty", eofQ.size() == 0, eofQ.size(), 0);
        chk("ovf_q_empty", ovfQ.size() == 0, ovfQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
